control_sequencer: RTL and testbench

Moore-style control unit that sequences the shared 32-bit datapath bus and its register load enables through the fetch and execute steps of the Mini SRC.
- Each cycle it selects at most one bus source (one-hot), asserts the matching destination loads and drives the ALU opcode.
- It stalls on a memory-ready handshake.
- It sits between the instruction register, the register file select logic (Gra/Grb/Grc) and the bus multiplexer.

---
 rtl/mini_src_pkg.sv | 95 +++++++++
 rtl/ctl_decode.sv | 122 ++++++++++++
 rtl/control_sequencer.sv | 113 +++++++++++
 tb/tb_control_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// -----------------------------------------------------------------------------
// mini_src_pkg
// Shared definitions for the Mini SRC control path:
//   - opcode constants (IR[31:27])
//   - bus source indices, shared with the bus multiplexer
//   - sequencer state encoding and the decoded control-word struct
//   - opcode classification helpers used by the sequencer and its decoder
// -----------------------------------------------------------------------------
package mini_src_pkg;

  localparam int OP_W   = 5;
  localparam int NSRC_W = 8;

  // Opcodes. ADD..SHL bound the contiguous reg-reg ALU range.
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // Bus source indices (bit positions in bus_sel).
  localparam int SRC_R0R15  = 0;
  localparam int SRC_HI     = 1;
  localparam int SRC_LO     = 2;
  localparam int SRC_ZHI    = 3;
  localparam int SRC_ZLO    = 4;
  localparam int SRC_PC     = 5;
  localparam int SRC_MDR    = 6;
  localparam int SRC_INPORT = 7;

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, HALT, PAUSE
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_MULDIV, CLS_UNARY, CLS_MFHI, CLS_MFLO, CLS_IN, CLS_NOP, CLS_HALT
  } op_class_t;

  typedef struct packed {
    logic [NSRC_W-1:0] bus_sel;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic pc_in;
    logic ir_in;
    logic mar_in;
    logic mdr_in;
    logic y_in;
    logic z_in;
    logic hi_in;
    logic lo_in;
    logic inc_pc;
    logic mem_read;
    logic run;
  } ctl_t;

  // Unlisted opcodes fall into CLS_NOP: one empty execute step.
  function automatic op_class_t op_class(input logic [OP_W-1:0] op);
    op_class_t c;
    if (op >= OP_ADD && op <= OP_SHL) begin
      c = CLS_ALU;
    end else begin
      case (op)
        OP_MUL, OP_DIV: c = CLS_MULDIV;
        OP_NEG, OP_NOT: c = CLS_UNARY;
        OP_MFHI:        c = CLS_MFHI;
        OP_MFLO:        c = CLS_MFLO;
        OP_IN:          c = CLS_IN;
        OP_HALT:        c = CLS_HALT;
        default:        c = CLS_NOP;
      endcase
    end
    return c;
  endfunction

  // Final execute state of each class; that state returns to T0 or PAUSE.
  function automatic state_t last_exec_state(input op_class_t c);
    state_t s;
    case (c)
      CLS_ALU:    s = T5;
      CLS_MULDIV: s = T6;
      CLS_UNARY:  s = T4;
      default:    s = T3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctl_decode.sv
// -----------------------------------------------------------------------------
// ctl_decode
// Purely combinational map from sequencer state and opcode to the control word.
// Ports:
//   i_state   - current sequencer state
//   i_op      - opcode field from the instruction register
//   i_mem_rdy - memory read data valid (gates the MDR load during T1)
//   o_ctl     - decoded bus select, register selects and load enables
// -----------------------------------------------------------------------------
module ctl_decode
  import mini_src_pkg::*;
(
  input  state_t                i_state,
  input  logic [OP_W-1:0]       i_op,
  input  logic                  i_mem_rdy,
  output ctl_t                  o_ctl
);

  op_class_t w_cls;
  assign w_cls = op_class(i_op);

  always_comb begin
    o_ctl     = '0;
    o_ctl.run = (i_state != HALT) && (i_state != PAUSE);
    case (i_state)
      T0: begin
        o_ctl.bus_sel[SRC_PC] = 1'b1;
        o_ctl.mar_in          = 1'b1;
        o_ctl.inc_pc          = 1'b1;
        o_ctl.z_in            = 1'b1;
      end
      T1: begin
        o_ctl.bus_sel[SRC_ZLO] = 1'b1;
        o_ctl.pc_in            = 1'b1;
        o_ctl.mem_read         = 1'b1;
        // MDR only captures on the cycle memory actually returns data.
        o_ctl.mdr_in           = i_mem_rdy;
      end
      T2: begin
        o_ctl.bus_sel[SRC_MDR] = 1'b1;
        o_ctl.ir_in            = 1'b1;
      end
      T3: begin
        case (w_cls)
          CLS_ALU: begin
            o_ctl.grb                = 1'b1;
            o_ctl.bus_sel[SRC_R0R15] = 1'b1;
            o_ctl.y_in               = 1'b1;
          end
          CLS_MULDIV: begin
            o_ctl.gra                = 1'b1;
            o_ctl.bus_sel[SRC_R0R15] = 1'b1;
            o_ctl.y_in               = 1'b1;
          end
          CLS_UNARY: begin
            o_ctl.grb                = 1'b1;
            o_ctl.bus_sel[SRC_R0R15] = 1'b1;
            o_ctl.z_in               = 1'b1;
          end
          CLS_MFHI: begin
            o_ctl.bus_sel[SRC_HI] = 1'b1;
            o_ctl.gra             = 1'b1;
            o_ctl.r_in            = 1'b1;
          end
          CLS_MFLO: begin
            o_ctl.bus_sel[SRC_LO] = 1'b1;
            o_ctl.gra             = 1'b1;
            o_ctl.r_in            = 1'b1;
          end
          CLS_IN: begin
            o_ctl.bus_sel[SRC_INPORT] = 1'b1;
            o_ctl.gra                 = 1'b1;
            o_ctl.r_in                = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        case (w_cls)
          CLS_ALU: begin
            o_ctl.grc                = 1'b1;
            o_ctl.bus_sel[SRC_R0R15] = 1'b1;
            o_ctl.z_in               = 1'b1;
          end
          CLS_MULDIV: begin
            o_ctl.grb                = 1'b1;
            o_ctl.bus_sel[SRC_R0R15] = 1'b1;
            o_ctl.z_in               = 1'b1;
          end
          CLS_UNARY: begin
            o_ctl.bus_sel[SRC_ZLO] = 1'b1;
            o_ctl.gra              = 1'b1;
            o_ctl.r_in             = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (w_cls)
          CLS_ALU: begin
            o_ctl.bus_sel[SRC_ZLO] = 1'b1;
            o_ctl.gra              = 1'b1;
            o_ctl.r_in             = 1'b1;
          end
          CLS_MULDIV: begin
            o_ctl.bus_sel[SRC_ZLO] = 1'b1;
            o_ctl.lo_in            = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        if (w_cls == CLS_MULDIV) begin
          o_ctl.bus_sel[SRC_ZHI] = 1'b1;
          o_ctl.hi_in            = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Moore control unit stepping the Mini SRC datapath through fetch (T0-T2) and
// opcode-dependent execute steps (T3-T6), with HALT and PAUSE states.
// Ports:
//   clk, clr            - clock; asynchronous active-high reset to T0
//   ir_op               - opcode from IR[31:27]
//   mem_rdy             - memory read data valid (ends the T1 stall)
//   stop                - pause request, honoured at the last execute step
//   bus_sel             - one-hot bus source select
//   gra, grb, grc       - register field selects
//   r_in .. lo_in       - destination load enables
//   inc_pc, mem_read    - ALU PC+1 select, memory read strobe
//   alu_op              - ALU operation (follows ir_op)
//   run                 - high except in HALT and PAUSE
// -----------------------------------------------------------------------------
module control_sequencer
  import mini_src_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [OPW-1:0]  ir_op,
  input  logic            mem_rdy,
  input  logic            stop,
  output logic [NSRC-1:0] bus_sel,
  output logic            gra,
  output logic            grb,
  output logic            grc,
  output logic            r_in,
  output logic            pc_in,
  output logic            ir_in,
  output logic            mar_in,
  output logic            mdr_in,
  output logic            y_in,
  output logic            z_in,
  output logic            hi_in,
  output logic            lo_in,
  output logic            inc_pc,
  output logic            mem_read,
  output logic [OPW-1:0]  alu_op,
  output logic            run
);

  state_t          r_state;
  state_t          w_state_nxt;
  state_t          w_last;
  state_t          w_exit;
  logic            w_at_last;
  logic [OP_W-1:0] w_op;
  op_class_t       w_cls;
  ctl_t            w_ctl;
  ctl_t            w_out;

  assign w_op      = OP_W'(ir_op);
  assign w_cls     = op_class(w_op);
  assign w_last    = last_exec_state(w_cls);
  assign w_at_last = (r_state == w_last);
  assign w_exit    = stop ? PAUSE : T0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= T0;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      T0:      w_state_nxt = T1;
      T1:      w_state_nxt = mem_rdy ? T2 : T1;
      T2:      w_state_nxt = (w_cls == CLS_HALT) ? HALT : T3;
      T3:      w_state_nxt = w_at_last ? w_exit : T4;
      T4:      w_state_nxt = w_at_last ? w_exit : T5;
      T5:      w_state_nxt = w_at_last ? w_exit : T6;
      T6:      w_state_nxt = w_exit;
      HALT:    w_state_nxt = HALT;
      PAUSE:   w_state_nxt = stop ? PAUSE : T0;
      default: w_state_nxt = T0;
    endcase
  end

  ctl_decode u_decode (
    .i_state   (r_state),
    .i_op      (w_op),
    .i_mem_rdy (mem_rdy),
    .o_ctl     (w_ctl)
  );

  // The register sits at T0 during clr, so outputs are masked directly;
  // releasing clr exposes T0 decode in the same cycle.
  assign w_out    = clr ? '0 : w_ctl;

  assign bus_sel  = NSRC'(w_out.bus_sel);
  assign gra      = w_out.gra;
  assign grb      = w_out.grb;
  assign grc      = w_out.grc;
  assign r_in     = w_out.r_in;
  assign pc_in    = w_out.pc_in;
  assign ir_in    = w_out.ir_in;
  assign mar_in   = w_out.mar_in;
  assign mdr_in   = w_out.mdr_in;
  assign y_in     = w_out.y_in;
  assign z_in     = w_out.z_in;
  assign hi_in    = w_out.hi_in;
  assign lo_in    = w_out.lo_in;
  assign inc_pc   = w_out.inc_pc;
  assign mem_read = w_out.mem_read;
  assign run      = w_out.run;
  assign alu_op   = ir_op;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Scoreboard bench: each driven cycle pushes the expected control word built
// from per-instruction microstep tables; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       clr;
  logic [4:0] ir_op;
  logic       mem_rdy;
  logic       stop;
  logic [7:0] bus_sel;
  logic       gra, grb, grc, r_in, pc_in, ir_in, mar_in, mdr_in;
  logic       y_in, z_in, hi_in, lo_in, inc_pc, mem_read, run;
  logic [4:0] alu_op;

  typedef struct packed {
    logic run, mem_read, inc_pc, lo_in, hi_in, z_in, y_in, mdr_in;
    logic mar_in, ir_in, pc_in, r_in, grc, grb, gra;
    logic [7:0] bus_sel;
    logic [4:0] alu_op;
  } vec_t;

  typedef struct packed {
    logic       c;
    logic       r;
    logic       s;
    logic [4:0] op;
    vec_t       e;
  } rec_t;

  vec_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  vec_t mon_exp, mon_act;

  control_sequencer #(.OPW(5), .NSRC(8)) dut (
    .clk(clk), .clr(clr), .ir_op(ir_op), .mem_rdy(mem_rdy), .stop(stop),
    .bus_sel(bus_sel), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in),
    .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
    .inc_pc(inc_pc), .mem_read(mem_read), .alu_op(alu_op), .run(run)
  );

  always #5 clk = ~clk;

  function automatic vec_t dut_vec();
    vec_t v;
    v.run = run; v.mem_read = mem_read; v.inc_pc = inc_pc; v.lo_in = lo_in;
    v.hi_in = hi_in; v.z_in = z_in; v.y_in = y_in; v.mdr_in = mdr_in;
    v.mar_in = mar_in; v.ir_in = ir_in; v.pc_in = pc_in; v.r_in = r_in;
    v.grc = grc; v.grb = grb; v.gra = gra; v.bus_sel = bus_sel; v.alu_op = alu_op;
    return v;
  endfunction

  function automatic bit is_alu(input logic [4:0] op);
    return (op >= 5'b00011) && (op <= 5'b01011);
  endfunction

  // Number of execute steps after T2 for each instruction.
  function automatic int exec_len(input logic [4:0] op);
    if (is_alu(op)) return 3;
    case (op)
      5'b10000, 5'b01111: return 4;
      5'b10001, 5'b10010: return 2;
      5'b11011:           return 0;
      default:            return 1;
    endcase
  endfunction

  // Control word for execute step k (0 = first step after T2).
  function automatic vec_t exec_word(input logic [4:0] op, input int k);
    vec_t v = '0;
    v.run = 1'b1;
    if (is_alu(op)) begin
      case (k)
        0: begin v.grb = 1; v.bus_sel = 8'h01; v.y_in = 1; end
        1: begin v.grc = 1; v.bus_sel = 8'h01; v.z_in = 1; end
        default: begin v.bus_sel = 8'h10; v.gra = 1; v.r_in = 1; end
      endcase
    end else if (op == 5'b10000 || op == 5'b01111) begin
      case (k)
        0: begin v.gra = 1; v.bus_sel = 8'h01; v.y_in = 1; end
        1: begin v.grb = 1; v.bus_sel = 8'h01; v.z_in = 1; end
        2: begin v.bus_sel = 8'h10; v.lo_in = 1; end
        default: begin v.bus_sel = 8'h08; v.hi_in = 1; end
      endcase
    end else if (op == 5'b10001 || op == 5'b10010) begin
      if (k == 0) begin v.grb = 1; v.bus_sel = 8'h01; v.z_in = 1; end
      else begin v.bus_sel = 8'h10; v.gra = 1; v.r_in = 1; end
    end else if (op == 5'b11000) begin
      v.bus_sel = 8'h02; v.gra = 1; v.r_in = 1;
    end else if (op == 5'b11001) begin
      v.bus_sel = 8'h04; v.gra = 1; v.r_in = 1;
    end else if (op == 5'b10110) begin
      v.bus_sel = 8'h80; v.gra = 1; v.r_in = 1;
    end
    return v;
  endfunction

  // One instruction: fetch with 'stalls' not-ready cycles, execute, optional
  // pause of pause_len stop=1 cycles (-1: no stop), optional clr at record
  // abort_at (-1: none). Halt is followed by 20 idle cycles and a clr.
  task automatic run_instr(input logic [4:0] op, input int stalls,
                           input int pause_len, input int abort_at);
    rec_t recs[$];
    rec_t r;
    int   n;
    r = '0; r.op = 5'($urandom); r.r = 1'($urandom); r.s = 1'($urandom);
    r.e.run = 1; r.e.bus_sel = 8'h20; r.e.mar_in = 1; r.e.inc_pc = 1; r.e.z_in = 1;
    recs.push_back(r);
    for (int i = 0; i <= stalls; i++) begin
      r = '0; r.op = 5'($urandom); r.s = 1'($urandom); r.r = (i == stalls);
      r.e.run = 1; r.e.bus_sel = 8'h10; r.e.pc_in = 1; r.e.mem_read = 1;
      r.e.mdr_in = (i == stalls);
      recs.push_back(r);
    end
    r = '0; r.op = op; r.r = 1'($urandom); r.s = 1'($urandom);
    r.e.run = 1; r.e.bus_sel = 8'h40; r.e.ir_in = 1;
    recs.push_back(r);
    n = exec_len(op);
    if (n == 0) begin
      for (int i = 0; i < 20; i++) begin
        r = '0; r.op = op; r.r = 1'($urandom); r.s = 1'($urandom);
        recs.push_back(r);
      end
      r = '0; r.c = 1; r.op = op;
      recs.push_back(r);
    end else begin
      for (int k = 0; k < n; k++) begin
        r = '0; r.op = op; r.r = 1'($urandom);
        r.s = (k == n - 1) ? (pause_len >= 0) : 1'($urandom);
        r.e = exec_word(op, k);
        recs.push_back(r);
      end
      if (pause_len >= 0) begin
        for (int i = 0; i <= pause_len; i++) begin
          r = '0; r.op = op; r.r = 1'($urandom); r.s = (i < pause_len);
          recs.push_back(r);
        end
      end
    end
    if (abort_at >= 0 && abort_at < recs.size()) begin
      while (recs.size() > abort_at + 1) void'(recs.pop_back());
      recs[abort_at].c = 1'b1;
      recs[abort_at].e = '0;
    end
    foreach (recs[i]) begin
      @(posedge clk);
      #1;
      clr     = recs[i].c;
      mem_rdy = recs[i].r;
      stop    = recs[i].s;
      ir_op   = recs[i].op;
      r       = recs[i];
      r.e.alu_op = recs[i].op;
      q.push_back(r.e);
    end
  endtask

  // Scoreboard monitor: one expected word per driven cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_exp = q.pop_front();
      mon_act = dut_vec();
      vectors++;
      if (mon_act !== mon_exp)
        begin
          $display("FAIL ctl_word #%0d at %0t: got %h required %h",
                   vectors, $time, mon_act, mon_exp);
          miscompares++;
        end
    end
  end

  always @(negedge clk) begin
    assert ($onehot0(bus_sel)) else begin
      $display("FAIL bus_sel_onehot at %0t: got %b", $time, bus_sel);
      miscompares++;
    end
  end

  initial begin
    rec_t rst_rec;
    logic [4:0] op;
    int pl, ab;
    clr = 1'b1; mem_rdy = 1'b0; stop = 1'b0; ir_op = 5'b00011;
    // Reset state check.
    @(posedge clk); #1;
    rst_rec = '0; rst_rec.e.alu_op = ir_op;
    q.push_back(rst_rec.e);
    // Clear during T4 of an add, then a clean T0.
    run_instr(5'b00011, 0, -1, 4);
    // Fetch stalled 3 cycles, then a full add.
    run_instr(5'b00011, 3, -1, -1);
    run_instr(5'b10000, 0, -1, -1);
    run_instr(5'b01111, 1, -1, -1);
    run_instr(5'b10001, 0, -1, -1);
    run_instr(5'b11000, 0, -1, -1);
    run_instr(5'b10110, 2, -1, -1);
    run_instr(5'b11010, 0, -1, -1);
    run_instr(5'b11011, 0, -1, -1);
    // stop on the last mflo step, one stop=1 pause cycle before release.
    run_instr(5'b11001, 0, 1, -1);
    run_instr(5'b11001, 0, 0, -1);
    for (int i = 0; i < 150; i++) begin
      op = 5'($urandom);
      pl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_instr(op, int'($urandom_range(0, 3)), pl, ab);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d words pending, required 0", q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
